// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for a two-digit BCD stopwatch.
// Emits ones-digit increment pulses, counter clear and lap-frozen display.
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV    = 100_000_000,
   parameter bit          STOP_AT_MAX = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic [3:0] cnt_ones,
   input  logic [3:0] cnt_tens,
   output logic       inc,
   output logic       cnt_rst_n,
   output logic [3:0] disp_ones,
   output logic [3:0] disp_tens,
   output logic       running,
   output logic       done,
   output logic       wrapped
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PAUSE,
      S_LAP,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          inc_q, inc_d;
   logic          wrap_q, wrap_d;
   logic          rstn_q, rstn_d;
   logic [3:0]    lap_ones_q, lap_ones_d;
   logic [3:0]    lap_tens_q, lap_tens_d;

   logic b_clr, b_start, b_lap;
   logic active, at_max, tick;

   // clr beats start beats lap when pulses coincide
   assign b_clr   = btn_clr;
   assign b_start = btn_start & ~btn_clr;
   assign b_lap   = btn_lap & ~btn_start & ~btn_clr;

   assign active = (state_q == S_RUN) || (state_q == S_LAP);
   assign at_max = ({cnt_tens, cnt_ones} == 8'h99);
   assign tick   = active && (pre_q == PMAX) && !btn_start && !btn_clr;

   // next state, prescaler, pulses and lap capture
   always_comb begin
      state_d    = state_q;
      pre_d      = pre_q;
      inc_d      = 1'b0;
      wrap_d     = 1'b0;
      rstn_d     = 1'b1;
      lap_ones_d = lap_ones_q;
      lap_tens_d = lap_tens_q;

      // a start/clr pulse freezes the sub-tick phase for that cycle
      if (active) begin
         if (tick)
            pre_d = '0;
         else if (!btn_start && !btn_clr)
            pre_d = pre_q + PW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (b_clr) begin
               rstn_d = 1'b0;
            end else if (b_start) begin
               state_d = S_RUN;
               pre_d   = '0;
            end
         end
         S_RUN: begin
            if (b_start) begin
               state_d = S_PAUSE;
            end else if (b_lap) begin
               state_d    = S_LAP;
               lap_ones_d = cnt_ones;
               lap_tens_d = cnt_tens;
            end
         end
         S_LAP: begin
            if (b_start)
               state_d = S_PAUSE;
            else if (b_lap)
               state_d = S_RUN;
         end
         S_PAUSE: begin
            if (b_clr) begin
               state_d = S_IDLE;
               pre_d   = '0;
               rstn_d  = 1'b0;
            end else if (b_start) begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (b_clr) begin
               state_d = S_IDLE;
               pre_d   = '0;
               rstn_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // reaching 99 with halt enabled overrides any lap toggle
      if (tick) begin
         if (at_max && STOP_AT_MAX) begin
            state_d = S_DONE;
         end else begin
            inc_d  = 1'b1;
            wrap_d = at_max;
         end
      end
   end

   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pre_q      <= '0;
         inc_q      <= 1'b0;
         wrap_q     <= 1'b0;
         rstn_q     <= 1'b0;
         lap_ones_q <= 4'd0;
         lap_tens_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         inc_q      <= inc_d;
         wrap_q     <= wrap_d;
         rstn_q     <= rstn_d;
         lap_ones_q <= lap_ones_d;
         lap_tens_q <= lap_tens_d;
      end
   end

   // display shows the lap snapshot only while frozen
   always_comb begin
      disp_ones = cnt_ones;
      disp_tens = cnt_tens;
      if (state_q == S_LAP) begin
         disp_ones = lap_ones_q;
         disp_tens = lap_tens_q;
      end
   end

   assign inc       = inc_q;
   assign wrapped   = wrap_q;
   assign cnt_rst_n = rstn_q;
   assign running   = active;
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: halting and wrapping instances side by side,
// each driving a BCD counter, checked against an integer-count model.
module tb_stopwatch_ctrl;

   localparam int TD = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3, M_DONE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic bs = 1'b0, bl = 1'b0, bc = 1'b0;

   logic       inc0, rstn0, run0, dn0, wrp0;
   logic [3:0] do0, dt0;
   logic [3:0] co0 = 4'd0, ct0 = 4'd0;
   logic       inc1, rstn1, run1, dn1, wrp1;
   logic [3:0] do1, dt1;
   logic [3:0] co1 = 4'd0, ct1 = 4'd0;

   int nvec = 0;
   int nerr = 0;
   int wcount = 0;

   int m_st [2]   = '{0, 0};
   int m_pre [2]  = '{0, 0};
   int m_val [2]  = '{0, 0};
   int m_lap [2]  = '{0, 0};
   bit m_inc [2]  = '{0, 0};
   bit m_wrap [2] = '{0, 0};
   bit m_rstn [2] = '{0, 0};

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(TD), .STOP_AT_MAX(1'b1)) u0 (
      .clk(clk), .rst(rst),
      .btn_start(bs), .btn_lap(bl), .btn_clr(bc),
      .cnt_ones(co0), .cnt_tens(ct0),
      .inc(inc0), .cnt_rst_n(rstn0),
      .disp_ones(do0), .disp_tens(dt0),
      .running(run0), .done(dn0), .wrapped(wrp0)
   );

   stopwatch_ctrl #(.TICK_DIV(TD), .STOP_AT_MAX(1'b0)) u1 (
      .clk(clk), .rst(rst),
      .btn_start(bs), .btn_lap(bl), .btn_clr(bc),
      .cnt_ones(co1), .cnt_tens(ct1),
      .inc(inc1), .cnt_rst_n(rstn1),
      .disp_ones(do1), .disp_tens(dt1),
      .running(run1), .done(dn1), .wrapped(wrp1)
   );

   // external digit counters with asynchronous clear
   always @(posedge clk or negedge rstn0) begin
      if (!rstn0) begin
         co0 <= 4'd0;
         ct0 <= 4'd0;
      end else if (inc0) begin
         co0 <= (co0 == 4'd9) ? 4'd0 : co0 + 4'd1;
         if (co0 == 4'd9) ct0 <= (ct0 == 4'd9) ? 4'd0 : ct0 + 4'd1;
      end
   end

   always @(posedge clk or negedge rstn1) begin
      if (!rstn1) begin
         co1 <= 4'd0;
         ct1 <= 4'd0;
      end else if (inc1) begin
         co1 <= (co1 == 4'd9) ? 4'd0 : co1 + 4'd1;
         if (co1 == 4'd9) ct1 <= (ct1 == 4'd9) ? 4'd0 : ct1 + 4'd1;
      end
   end

   task automatic model(input bit s, input bit l, input bit c, input bit r);
      bit stop, act, tick, ps, pl, oinc, orstn, nrstn;
      int vis;
      for (int d = 0; d < 2; d++) begin
         if (r) begin
            m_st[d] = M_IDLE; m_pre[d] = 0; m_val[d] = 0; m_lap[d] = 0;
            m_inc[d] = 0; m_wrap[d] = 0; m_rstn[d] = 0;
         end else begin
            stop  = (d == 0);
            vis   = m_val[d];
            oinc  = m_inc[d];
            orstn = m_rstn[d];
            act   = (m_st[d] == M_RUN) || (m_st[d] == M_LAP);
            tick  = act && (m_pre[d] == TD - 1) && !s && !c;
            ps    = s && !c;
            pl    = l && !s && !c;
            nrstn = 1;
            m_inc[d]  = 0;
            m_wrap[d] = 0;
            if (act) begin
               if (tick) m_pre[d] = 0;
               else if (!s && !c) m_pre[d] = m_pre[d] + 1;
            end
            case (m_st[d])
               M_IDLE:
                  if (c) nrstn = 0;
                  else if (ps) begin m_st[d] = M_RUN; m_pre[d] = 0; end
               M_RUN:
                  if (ps) m_st[d] = M_PAUSE;
                  else if (pl) begin m_st[d] = M_LAP; m_lap[d] = vis; end
               M_LAP:
                  if (ps) m_st[d] = M_PAUSE;
                  else if (pl) m_st[d] = M_RUN;
               M_PAUSE:
                  if (c) begin m_st[d] = M_IDLE; m_pre[d] = 0; nrstn = 0; end
                  else if (ps) m_st[d] = M_RUN;
               default:
                  if (c) begin m_st[d] = M_IDLE; m_pre[d] = 0; nrstn = 0; end
            endcase
            if (tick) begin
               if (vis == 99 && stop) m_st[d] = M_DONE;
               else begin m_inc[d] = 1; m_wrap[d] = (vis == 99); end
            end
            m_rstn[d] = nrstn;
            if (!nrstn || !orstn) m_val[d] = 0;
            else if (oinc) m_val[d] = (m_val[d] + 1) % 100;
         end
      end
   endtask

   function automatic logic [12:0] expv(input int d);
      int dv;
      dv = (m_st[d] == M_LAP) ? m_lap[d] : m_val[d];
      return {m_inc[d], m_wrap[d], m_rstn[d],
              (m_st[d] == M_RUN) || (m_st[d] == M_LAP),
              m_st[d] == M_DONE, 4'(dv / 10), 4'(dv % 10)};
   endfunction

   task automatic chk(input string tag, input logic [12:0] got,
                      input logic [12:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input bit s, input bit l, input bit c, input bit r);
      bs = s; bl = l; bc = c; rst = r;
      @(posedge clk);
      model(s, l, c, r);
      #1;
      if (wrp1) wcount++;
      chk("halt", {inc0, wrp0, rstn0, run0, dn0, dt0, do0}, expv(0));
      chk("wrap", {inc1, wrp1, rstn1, run1, dn1, dt1, do1}, expv(1));
      bs = 0; bl = 0; bc = 0; rst = 0;
   endtask

   initial begin
      int n;
      // reset, then plain counting
      repeat (3) step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (14) step(0, 0, 0, 0);
      // pause with prescaler at 2, hold, resume
      n = 0;
      while (m_pre[0] != 2 && n < 10) begin step(0, 0, 0, 0); n++; end
      step(1, 0, 0, 0);
      repeat (20) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0);
      // lap at 07, freeze while counting to 10
      n = 0;
      while (m_val[0] != 7 && n < 100) begin step(0, 0, 0, 0); n++; end
      step(0, 1, 0, 0);
      n = 0;
      while (m_val[0] != 10 && n < 40) begin step(0, 0, 0, 0); n++; end
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (2) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      // coincident buttons
      step(1, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0);
      step(1, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      step(1, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);
      // full sweep: halting copy stops at 99, wrapping copy rolls over
      step(1, 0, 0, 0);
      n = 0;
      while (m_st[0] != M_DONE && n < 600) begin step(0, 0, 0, 0); n++; end
      repeat (6) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      chk("wrapseen", {12'd0, wcount > 0}, 13'd1);
      step(0, 0, 1, 0);
      repeat (3) step(0, 0, 0, 0);
      // reset in the middle of a run
      step(1, 0, 0, 0);
      repeat (9) step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      repeat (3) step(0, 0, 0, 0);
      // randomized buttons and occasional reset
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 11) == 0, $urandom_range(0, 13) == 0,
              $urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the two-digit BCD stopwatch. It turns debounced button pulses into run/pause/lap/clear behaviour and generates the one-cycle `increase` pulses for the ones-digit counter. The ones digit's `carry` drives the tens digit externally. The controller also issues the counters' active-low reset and freezes the displayed value for lap timing. It sits between the button debouncers and the pair of digit counters, and feeds the seven-segment driver.

## Interface
- TICK_DIV, default 100_000_000: clock cycles per count tick. Must be ≥ 2.
- STOP_AT_MAX, default 1: 1 = halt at 99 (DONE); 0 = wrap 99→00.
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- btn_start  in  1  one-cycle pulse; toggles run/pause.
- btn_lap  in  1  one-cycle pulse; enters or leaves lap freeze.
- btn_clr  in  1  one-cycle pulse; clears the count.
- cnt_ones  in  4  live ones-digit value from the counter.
- cnt_tens  in  4  live tens-digit value from the counter.
- inc  out  1  registered; drives the ones counter `increase`.
- cnt_rst_n  out  1  registered; active-low reset to both digit counters.
- disp_ones  out  4  ones digit to the display.
- disp_tens  out  4  tens digit to the display.
- running  out  1  high in RUN or LAP.
- done  out  1  high in DONE.
- wrapped  out  1  one-cycle pulse on a 99→00 tick; only possible when STOP_AT_MAX=0.

## Operation
- States: IDLE, RUN, PAUSE, LAP, DONE. Encoding is free; running and done decode from the state.
- Button priority when several pulse in the same cycle: clr > start > lap. Lower-priority pulses are ignored in that cycle.
- IDLE:
  - start → RUN, prescaler cleared to 0.
  - clr → stay IDLE, issue a counter clear.
  - lap is ignored.
- RUN:
  - start → PAUSE.
  - lap → LAP, snapshot cnt_tens/cnt_ones into the lap registers.
  - clr is ignored.
  - max detect → DONE (below).
- LAP:
  - lap → RUN, display returns to live.
  - start → PAUSE, display returns to live.
  - Counting continues exactly as in RUN.
  - clr is ignored.
- PAUSE:
  - start → RUN, prescaler resumes from its held value.
  - clr → IDLE, issue a counter clear, prescaler cleared.
  - lap is ignored.
- DONE:
  - clr → IDLE, issue a counter clear, prescaler cleared.
  - All other buttons are ignored.
- Prescaler: 0..TICK_DIV-1. It advances only in RUN/LAP and holds in PAUSE and DONE. It is sized by $clog2(TICK_DIV).
- Tick: occurs when in RUN/LAP and prescaler == TICK_DIV-1 and no start/clr pulse in that cycle.
  - On the tick, prescaler ← 0.
  - If {cnt_tens,cnt_ones} == 8'h99 and STOP_AT_MAX=1: state ← DONE, inc stays 0.
  - Else: inc ← 1 for the next cycle. If the value is 99 (only reachable with STOP_AT_MAX=0), wrapped ← 1 for the same cycle.
- Counter clear: cnt_rst_n ← 0 for exactly one cycle.
- Display:
  - LAP: disp_* = lap registers.
  - All other states: disp_* = cnt_* (combinational pass-through).

## Timing
- Reset values while rst is high and in the cycle after: state IDLE, prescaler 0, inc 0, wrapped 0, lap registers 0, cnt_rst_n 0.
  - Because cnt_rst_n is registered, the counters are held cleared during rst.
  - cnt_rst_n goes 1 on the first edge where rst is sampled low.
- Derived outputs in reset: running 0, done 0, disp_* = cnt_* = 0.
- Button response: a pulse sampled at edge E changes state at E. running/done reflect the new state from E onward.
- inc timing:
  - inc is high exactly one cycle, the cycle after the tick edge.
  - The counter increments on the following edge, so the displayed value changes 2 edges after the tick.
  - Period is TICK_DIV cycles in steady RUN.
- First inc after start from IDLE appears TICK_DIV cycles after the start edge.
- Pause/resume preserves the sub-tick phase.
  - A start pulse coinciding with prescaler == TICK_DIV-1 suppresses that tick, and the prescaler holds at TICK_DIV-1.
  - The first inc then follows one cycle after the resume edge.
- Counter clear timing: clr sampled at E → cnt_rst_n low during cycle E..E+1 → counters read 0 after the async reset takes effect.
- rst mid-run (any state): the same reset behaviour applies on the next edge. An inc already high is dropped to 0.

## Test plan
1. TICK_DIV=4. Reset, then start.
   - Required: inc pulses at cycles 4, 8, 12… after the start edge.
   - Required: display reads 01, 02, 03… and running=1.
2. TICK_DIV=4, STOP_AT_MAX=1. Run from 00 to 99.
   - Required: no inc on the tick while at 99.
   - Required: done=1, display holds 99, start and lap are ignored.
   - Then clr: cnt_rst_n low 1 cycle, display 00, state IDLE.
3. TICK_DIV=4, STOP_AT_MAX=0. Run from 98 through the wrap.
   - Required: inc then wrapped pulse on the 99 tick, display 00.
   - Required: counting continues, running stays 1.
4. Pause at prescaler=2, hold 20 cycles, resume.
   - Required: no inc while paused.
   - Required: first inc 2 cycles after the resume edge, value unchanged during the pause.
5. Lap at display 07, run 3 more ticks.
   - Required: disp stays 07 while the counters reach 10.
   - Second lap: disp 10 immediately.
   - Start during LAP → PAUSE with a live display.
6. Same-cycle start+lap in RUN → PAUSE only.
   - Same-cycle clr+start in PAUSE → IDLE plus counter clear.
   - rst pulsed mid-RUN → IDLE, inc 0, cnt_rst_n low, display 00.
